// File: rtl/hazard_track_unit_pkg.sv
// Shared definitions for the hazard tracking unit: forwarding select encodings,
// slot field widths, busy-FSM states and slot flag payload.
package hazard_track_unit_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned STAT_W     = 16;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic load;
    logic store;
    logic multi;
    logic use_rs1;
    logic use_rs2;
  } slot_flags_t;

endpackage

// File: rtl/hazard_track_unit_src_match.sv
// Compares one source register address against a tracked slot's destination;
// register 0 is hardwired zero and never matches.
module hazard_src_match #(
  parameter int unsigned AW = 5
) (
  input  logic          valid,
  input  logic          reg_write,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] src,
  output logic          match_c
);

  assign match_c = valid & reg_write & (rd == src) & (src != '0);

endmodule

// File: rtl/hazard_track_unit.sv
// EX/MEM/WB hazard tracker: operand and store-data forwarding, load-use and
// multi-cycle stalls. Define HAZARD_STATS_EN to add stall-cause counters.
module hazard_track_unit
  import hazard_track_unit_pkg::*;
#(
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_store,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_multi,
  input  logic              flush,
  output logic              stall,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              mem_store_fwd
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_lu,
  output logic [STAT_W-1:0] stat_mc
`endif
);

  typedef struct packed {
    slot_flags_t       f;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } slot_t;

  slot_t       ex_q, mem_q, wb_q;
  slot_t       ex_d, mem_d, wb_d;
  slot_t       id_slot;
  busy_state_e state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  logic lu_c, mc_c, take_id_c;
  logic m_ex_id1, m_ex_id2;
  logic m_mem_a, m_mem_b, m_wb_a, m_wb_b, m_wb_st;
  logic unused_slot_bits;

  // Source/slot comparators: ID sources vs EX, EX sources vs MEM/WB, MEM store data vs WB.
  hazard_src_match #(.AW(REG_AW)) u_ex_id1 (
    .valid(ex_q.f.valid), .reg_write(ex_q.f.reg_write), .rd(ex_q.rd), .src(id_rs1), .match_c(m_ex_id1));
  hazard_src_match #(.AW(REG_AW)) u_ex_id2 (
    .valid(ex_q.f.valid), .reg_write(ex_q.f.reg_write), .rd(ex_q.rd), .src(id_rs2), .match_c(m_ex_id2));
  hazard_src_match #(.AW(REG_AW)) u_mem_a (
    .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .rd(mem_q.rd), .src(ex_q.rs1), .match_c(m_mem_a));
  hazard_src_match #(.AW(REG_AW)) u_mem_b (
    .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .rd(mem_q.rd), .src(ex_q.rs2), .match_c(m_mem_b));
  hazard_src_match #(.AW(REG_AW)) u_wb_a (
    .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .rd(wb_q.rd), .src(ex_q.rs1), .match_c(m_wb_a));
  hazard_src_match #(.AW(REG_AW)) u_wb_b (
    .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .rd(wb_q.rd), .src(ex_q.rs2), .match_c(m_wb_b));
  hazard_src_match #(.AW(REG_AW)) u_wb_st (
    .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .rd(wb_q.rd), .src(mem_q.rs2), .match_c(m_wb_st));

  // Several slot fields only travel down the pipe for observability.
  assign unused_slot_bits = ^{ex_q.f.multi, ex_q.f.store, mem_q, wb_q};

  function automatic logic [FWD_W-1:0] fwd_sel(input logic use_src, input logic m_mem,
                                               input logic mem_load, input logic m_wb);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (m_mem && !mem_load) sel = FWD_MEM;
      else if (m_wb)          sel = FWD_WB;
    end
    return sel;
  endfunction

  assign lu_c = ex_q.f.load & ((m_ex_id1 & id_use_rs1) | (m_ex_id2 & id_use_rs2));
  assign mc_c = (busy_cnt_q != '0);
  assign stall = id_valid & (lu_c | mc_c) & ~flush;
  assign take_id_c = id_valid & ~lu_c & ~flush;

  assign fwd_a = ex_q.f.valid ? fwd_sel(ex_q.f.use_rs1, m_mem_a, mem_q.f.load, m_wb_a) : FWD_RF;
  assign fwd_b = ex_q.f.valid ? fwd_sel(ex_q.f.use_rs2, m_mem_b, mem_q.f.load, m_wb_b) : FWD_RF;
  assign mem_store_fwd = mem_q.f.valid & mem_q.f.store & m_wb_st;

  // Next-state: slot advance and busy counter FSM.
  always_comb begin
    id_slot    = '0;
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    ex_d       = ex_q;
    mem_d      = mc_c ? slot_t'('0) : ex_q;
    wb_d       = mem_q;

    id_slot.f.valid     = 1'b1;
    id_slot.f.reg_write = id_reg_write;
    id_slot.f.load      = id_load;
    id_slot.f.store     = id_store;
    id_slot.f.multi     = id_multi;
    id_slot.f.use_rs1   = id_use_rs1;
    id_slot.f.use_rs2   = id_use_rs2;
    id_slot.rd          = id_rd;
    id_slot.rs1         = id_rs1;
    id_slot.rs2         = id_rs2;

    case (state_q)
      ST_IDLE: begin
        ex_d = take_id_c ? id_slot : slot_t'('0);
        if (take_id_c && id_multi) begin
          busy_cnt_d = CNT_W'(MULTI_LAT - 1);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_cnt_d = busy_cnt_q - CNT_W'(1);
        if (busy_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush kills the EX instruction and aborts any multi-cycle op in flight.
    if (flush) begin
      ex_d       = '0;
      busy_cnt_d = '0;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_cnt_q <= '0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating stall-cause counters; a multi-cycle stall wins attribution.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lu <= '0;
      stat_mc <= '0;
    end else if (stall) begin
      if (mc_c) begin
        if (stat_mc != '1) stat_mc <= stat_mc + STAT_W'(1);
      end else if (lu_c) begin
        if (stat_lu != '1) stat_lu <= stat_lu + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Self-checking bench for hazard_track_unit: directed pipeline scenarios with
// literal expectations plus randomized traffic against an instruction-level model.
module tb_hazard_track_unit;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned MULTI_LAT = 4;
  localparam int unsigned CNT_W     = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_store, id_reg_write, id_load, id_multi;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a, fwd_b;
  logic              mem_store_fwd;
`ifdef HAZARD_STATS_EN
  logic [15:0]       stat_lu, stat_mc;
`endif

  always #5 clk = ~clk;

  hazard_track_unit #(.REG_AW(REG_AW), .MULTI_LAT(MULTI_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_store(id_store), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_load(id_load), .id_multi(id_multi), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_store_fwd(mem_store_fwd)
`ifdef HAZARD_STATS_EN
    , .stat_lu(stat_lu), .stat_mc(stat_mc)
`endif
  );

  // Instruction-level model: each pipe stage holds one instruction record.
  typedef struct {
    bit v, rw, ld, st, mu, u1, u2;
    int rd, rs1, rs2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_busy;
  int   n_pass = 0;
  int   n_checks = 0;
  int   o_stall, o_fwd_a, o_fwd_b, o_msf;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit writes(input ins_t s, input int r);
    return s.v && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic ins_t cur_id();
    ins_t i;
    i.v = 1'b1; i.rw = id_reg_write; i.ld = id_load; i.st = id_store; i.mu = id_multi;
    i.u1 = id_use_rs1; i.u2 = id_use_rs2;
    i.rd = int'(id_rd); i.rs1 = int'(id_rs1); i.rs2 = int'(id_rs2);
    return i;
  endfunction

  function automatic bit m_lu();
    return m_ex.v && m_ex.ld && ((id_use_rs1 && writes(m_ex, int'(id_rs1))) ||
                                 (id_use_rs2 && writes(m_ex, int'(id_rs2))));
  endfunction

  function automatic int fsel(input bit u, input int r);
    if (!m_ex.v || !u) return 0;
    if (writes(m_mem, r) && !m_mem.ld) return 1;
    if (writes(m_wb, r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0}; m_busy = 0;
  endtask

  task automatic model_advance();
    bit lu, mc;
    ins_t bubble;
    bubble = '{default: 0};
    lu = m_lu();
    mc = (m_busy > 0);
    m_wb  = m_mem;
    m_mem = mc ? bubble : m_ex;
    if (flush) begin
      m_ex = bubble; m_busy = 0;
    end else if (mc) begin
      m_busy = m_busy - 1;
    end else if (lu || !id_valid) begin
      m_ex = bubble;
    end else begin
      m_ex = cur_id();
      m_busy = id_multi ? int'(MULTI_LAT) - 1 : 0;
    end
  endtask

  task automatic compare_model();
    int e_stall;
    e_stall = (id_valid && (m_lu() || m_busy > 0) && !flush) ? 1 : 0;
    check("model_stall", int'(stall), e_stall);
    check("model_fwd_a", int'(fwd_a), fsel(m_ex.u1, m_ex.rs1));
    check("model_fwd_b", int'(fwd_b), fsel(m_ex.u2, m_ex.rs2));
    check("model_mem_store_fwd", int'(mem_store_fwd),
          (m_mem.v && m_mem.st && writes(m_wb, m_mem.rs2)) ? 1 : 0);
  endtask

  // One clock: sample and check mid-cycle, then advance the model with the DUT.
  task automatic step();
    @(negedge clk);
    compare_model();
    o_stall = int'(stall); o_fwd_a = int'(fwd_a); o_fwd_b = int'(fwd_b); o_msf = int'(mem_store_fwd);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_id(input bit v, input int rd, input int rs1, input int rs2, input bit rw,
                        input bit ld, input bit st, input bit mu, input bit u1, input bit u2,
                        input bit fl);
    id_valid = v; id_rd = REG_AW'(rd); id_rs1 = REG_AW'(rs1); id_rs2 = REG_AW'(rs2);
    id_reg_write = rw; id_load = ld; id_store = st; id_multi = mu;
    id_use_rs1 = u1; id_use_rs2 = u2; flush = fl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic rand_id();
    int kind;
    id_valid = ($urandom_range(0, 9) < 8);
    id_rd = REG_AW'($urandom_range(0, 3));
    id_rs1 = REG_AW'($urandom_range(0, 3));
    id_rs2 = REG_AW'($urandom_range(0, 3));
    id_reg_write = 1'b1; id_load = 1'b0; id_store = 1'b0; id_multi = 1'b0;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
    kind = int'($urandom_range(0, 9));
    if (kind <= 2) id_load = 1'b1;
    else if (kind == 3) begin id_store = 1'b1; id_reg_write = 1'b0; end
    else if (kind == 4) begin id_multi = 1'b1; id_use_rs2 = 1'b1; end
    else if (kind == 5) id_use_rs1 = 1'b0;
    else id_use_rs2 = 1'($urandom_range(0, 1));
    flush = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    // Reset held for three cycles under random inputs.
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      rand_id();
      @(negedge clk);
      check("reset_stall", int'(stall), 0);
      check("reset_fwd", int'({fwd_a, fwd_b}), 0);
      check("reset_msf", int'(mem_store_fwd), 0);
      @(posedge clk);
    end
    #2 reset_n = 1'b1;

    // ADD r3 ; SUB r5,r3,r3 ; OR r7,r3
    drain();
    set_id(1, 3, 1, 2, 1, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 5, 3, 3, 1, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 7, 3, 0, 1, 0, 0, 0, 1, 0, 0); step();
    check("exmem_fwd_a", o_fwd_a, 1);
    check("exmem_fwd_b", o_fwd_b, 1);
    idle(); step();
    check("exwb_fwd_a", o_fwd_a, 2);
    check("exwb_fwd_b", o_fwd_b, 0);

    // LW r4 ; ADD r6,r4,r1 -> one stall cycle, then WB forwarding
    drain();
    set_id(1, 4, 2, 0, 1, 1, 0, 0, 1, 0, 0); step();
    set_id(1, 6, 4, 1, 1, 0, 0, 0, 1, 1, 0); step();
    check("lu_stall_first", o_stall, 1);
    step();
    check("lu_stall_second", o_stall, 0);
    check("lu_bubble_fwd_a", o_fwd_a, 0);
    idle(); step();
    check("lu_fwd_a_wb", o_fwd_a, 2);
    check("lu_fwd_b", o_fwd_b, 0);

    // LW r4 ; SW r4,0(r2) -> no stall, store data from WB
    drain();
    set_id(1, 4, 2, 0, 1, 1, 0, 0, 1, 0, 0); step();
    set_id(1, 0, 2, 4, 0, 0, 1, 0, 1, 0, 0); step();
    check("ldst_no_stall", o_stall, 0);
    idle(); step();
    check("ldst_msf_early", o_msf, 0);
    step();
    check("ldst_msf", o_msf, 1);

    // MUL r8 ; ADD r9,r8,r11 -> three stall cycles, MUL leaves EX after four
    drain();
    set_id(1, 8, 1, 2, 1, 0, 0, 1, 1, 1, 0); step();
    set_id(1, 9, 8, 11, 1, 0, 0, 0, 1, 1, 0);
    step(); check("mc_stall_1", o_stall, 1);
    step(); check("mc_stall_2", o_stall, 1);
    step(); check("mc_stall_3", o_stall, 1);
    step(); check("mc_stall_end", o_stall, 0);
    idle(); step();
    check("mc_fwd_a_mem", o_fwd_a, 1);

    // Flush while the multi op has two cycles of busy count left
    drain();
    set_id(1, 8, 1, 2, 1, 0, 0, 1, 1, 1, 0); step();
    set_id(1, 9, 8, 11, 1, 0, 0, 0, 1, 1, 0); step();
    check("fl_pre_stall", o_stall, 1);
    set_id(1, 9, 8, 11, 1, 0, 0, 0, 1, 1, 1); step();
    check("fl_during_stall", o_stall, 0);
    set_id(1, 9, 8, 11, 1, 0, 0, 0, 1, 1, 0); step();
    check("fl_after_stall", o_stall, 0);
    idle(); step();
    check("fl_no_fwd", o_fwd_a, 0);

    // Destination r0 never forwards and never load-use stalls
    drain();
    set_id(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0); step();
    set_id(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 0); step();
    check("r0_no_stall", o_stall, 0);
    idle(); step();
    check("r0_fwd_a", o_fwd_a, 0);
    check("r0_fwd_b", o_fwd_b, 0);

    // Async reset mid multi op: stall clears immediately and stays clear
    drain();
    set_id(1, 8, 1, 2, 1, 0, 0, 1, 1, 1, 0); step();
    set_id(1, 9, 8, 11, 1, 0, 0, 0, 1, 1, 0); step();
    check("ar_pre_stall", o_stall, 1);
    #2 reset_n = 1'b0;
    #1 check("ar_async_stall", int'(stall), 0);
    model_reset();
    @(negedge clk);
    check("ar_hold_stall", int'(stall), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    check("ar_post_stall", o_stall, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rand_id();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
